core_bus_bridge: RTL



---
 rtl/core_bus_bridge.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/core_bus_bridge.sv
// core_bus_bridge: arbitrates the CPU instruction port (ireq/iresp) and data port (dreq/dresp)
// onto a single memory port (mreq/mresp) with one transaction in flight at a time.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   ireq_* / iresp_*             instruction port: request in; addr_ok / data_ok / data out
//   dreq_* / dresp_*             data port: request in; addr_ok / data_ok / data out
//   mreq_* / mresp_*             memory port: registered request out; responses in
//   bus_timeout                  sticky watchdog flag
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin arbitration under contention (priority starts at data)
//              undefined -> fixed data-over-instruction priority
module core_bus_bridge #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  // instruction port
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_addr_ok,
  output logic                iresp_data_ok,
  output logic [DATA_W-1:0]   iresp_data,
  // data port
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_addr_ok,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,
  // memory port
  output logic                mreq_valid,
  output logic [ADDR_W-1:0]   mreq_addr,
  output logic [2:0]          mreq_size,
  output logic [DATA_W/8-1:0] mreq_strobe,
  output logic [DATA_W-1:0]   mreq_data,
  input  logic                mresp_addr_ok,
  input  logic                mresp_data_ok,
  input  logic [DATA_W-1:0]   mresp_data,
  output logic                bus_timeout
);

  localparam int unsigned StrbW  = DATA_W / 8;
  localparam int unsigned CntW   = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_LIMIT);
  localparam logic [2:0]  SizeWord = 3'b010;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // 1: data port owns the transaction
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [StrbW-1:0]  strobe_q, strobe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic grant_valid;  // a request is accepted this cycle
  logic grant_dport;  // winner is the data port
  logic done;         // transaction completes this cycle
  logic busy;

`ifdef ARB_RR_EN
  logic prio_q, prio_d;        // 1: data port preferred on the next contention
  logic contend_q, contend_d;  // current transaction was granted under contention
`endif

  // Arbitration
  always_comb begin
    grant_valid = (state_q == StIdle) && (ireq_valid || dreq_valid);
`ifdef ARB_RR_EN
    if (ireq_valid && dreq_valid) begin
      grant_dport = prio_q;
    end else begin
      grant_dport = dreq_valid;
    end
`else
    grant_dport = dreq_valid;
`endif
  end

  // Next-state, request buffer and completion
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StAddr;
          owner_d = grant_dport;
          if (grant_dport) begin
            addr_d   = dreq_addr;
            size_d   = dreq_size;
            strobe_d = dreq_strobe;
            data_d   = dreq_data;
          end else begin
            addr_d   = ireq_addr;
            size_d   = SizeWord;
            strobe_d = '0;
            data_d   = '0;
          end
        end
      end
      StAddr: begin
        if (mresp_addr_ok) begin
          if (mresp_data_ok) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (mresp_data_ok) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Watchdog: counts cycles in the current busy state, saturating at the limit
  always_comb begin
    busy = (state_q != StIdle);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    timeout_d = timeout_q | (busy && (cnt_d == CntMax));
  end

`ifdef ARB_RR_EN
  always_comb begin
    contend_d = contend_q;
    prio_d    = prio_q;
    if (grant_valid) begin
      contend_d = ireq_valid && dreq_valid;
    end
    if (done && contend_q) begin
      prio_d = ~prio_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio_q    <= 1'b1;
      contend_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      contend_q <= contend_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      strobe_q  <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      strobe_q  <= strobe_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs
  always_comb begin
    iresp_addr_ok = grant_valid && !grant_dport;
    dresp_addr_ok = grant_valid && grant_dport;
    iresp_data_ok = done && !owner_q;
    dresp_data_ok = done && owner_q;
    iresp_data    = iresp_data_ok ? mresp_data : '0;
    dresp_data    = dresp_data_ok ? mresp_data : '0;
    mreq_valid    = (state_q == StAddr);
    mreq_addr     = addr_q;
    mreq_size     = size_q;
    mreq_strobe   = strobe_q;
    mreq_data     = data_q;
    bus_timeout   = timeout_q;
  end

endmodule
